pulse_train_generator: RTL and testbench
========================================

// Module: pulse_train_generator
// PURPOSE
//   Multi-channel successor to the single-channel pulse generator. Each channel emits a periodic
//   train with programmable period and high time (duty), either continuously or as a counted burst.
//   Used for LED/servo/PWM drive and timed strobes off the single system clock.
//   Per-channel counters; shared global enable.
// PARAMETERS
//   N        8  width of period/high-time/phase fields, in clock ticks
//   CHANNELS 2  number of independent channels (>=1)
//   BURST_W  8  width of the burst-length field
// PORTS
//   clk         in   1             system clock; all logic on posedge
//   rst         in   1             synchronous, active-low reset (0 = reset)
//   ena         in   1             global enable; 0 freezes all channels
//   ch_ena      in   CHANNELS      per-channel enable
//   ticks       in   CHANNELS*N    period in clock ticks, ch i at [i*N +: N]
//   high_ticks  in   CHANNELS*N    high time per period, ch i at [i*N +: N]
//   mode        in   CHANNELS      0 = continuous, 1 = burst
//   burst_len   in   CHANNELS*BURST_W  periods per burst, ch i at [i*BURST_W +: BURST_W]
//   start       in   CHANNELS      burst trigger, sampled per cycle (burst mode only)
//   out         out  CHANNELS      registered pulse outputs
//   busy        out  CHANNELS      1 while channel is in RUN
//   done        out  CHANNELS      1-cycle pulse when a burst completes
// BEHAVIOUR
//   - Reset (rst==0 at posedge): every channel IDLE; out=0, busy=0, done=0, count=0, period cnt=0.
//   - Per-channel FSM, two states: IDLE, RUN.
//   - IDLE->RUN at a posedge where ena & ch_ena & ticks!=0 and (mode==0 or start==1).
//     - That edge latches ticks/high_ticks/burst_len into shadow regs.
//     - count=0; out=(0<high_l); busy=1. Zero-cycle latency from the sampling edge.
//   - RUN, ena==1: count advances each cycle; at count==ticks_l-1 it wraps to 0.
//     - On wrap, shadow regs reload from ports: period/duty changes take effect only at a boundary.
//     - out=(count_next < high_l), registered.
//     - high_l==0 -> out stays 0; high_l>=ticks_l -> out stays 1.
//   - ena==0: count, FSM and shadows freeze; out forced 0; resume from the frozen count when ena
//     returns to 1.
//   - ch_ena==0 in any state: next edge -> IDLE, count=0, out=0, busy=0, no done.
//   - ticks==0 (latched or on entry): channel stays IDLE, out=0.
//   - Continuous mode: start ignored; runs until ch_ena falls.
//   - Burst mode:
//     - Period counter increments on each wrap.
//     - At the wrap ending period burst_len_l: ->IDLE, busy=0, out=0, done=1 for exactly 1 cycle.
//     - burst_len==0 at start: no RUN entry; done=1 on the next cycle, out stays 0.
//     - start while busy is ignored (no retrigger/extend).
//     - start coincident with the done edge is ignored; re-arming needs start in a later cycle.
//   - mode change while RUN takes effect only in IDLE (mode latched on entry).
//   - Channels are fully independent; no shared arithmetic overflow.
//     - count is N bits; ticks up to 2^N-1.
//   - Reset mid-burst: immediate IDLE, no done pulse.
// CONFIGURATION
//   PULSE_TRAIN_PHASE_EN defined:
//     - adds input port phase, CHANNELS*N, ch i at [i*N +: N].
//     - On IDLE->RUN, count loads phase instead of 0 (phase>=ticks loads 0).
//     - out=(phase<high_l) on the entry edge.
//     - For burst counting, the first, partial period counts as a full period.
//   Not defined: no phase port; count always starts at 0.
// TESTING
//   1 CHANNELS=2, N=3, ticks=6, high_ticks=3, mode=0, hold rst low 2 cycles then release
//     -> out = 3 high / 3 low repeating for 10 periods; busy=1; done never asserts.
//   2 ena dropped mid-period at count=4 for 5 cycles
//     -> out=0 while frozen; on re-enable the remaining 1 low cycle, then high resumes.
//   3 mode=1, burst_len=3, 1-cycle start
//     -> exactly 3 pulses, done=1 for 1 cycle on the 18th edge, busy falls on that same edge.
//     - start again while busy -> no effect.
//   4 high_ticks=0 -> out constantly 0; high_ticks=7 with ticks=6 -> constantly 1;
//     ticks=0 -> busy stays 0.
//   5 change ticks 6->4 at count=2 -> current period completes at 6, next period is 4;
//     ch1 unaffected.
//   6 rst low mid-burst -> out, busy, done all 0 next edge; no done pulse.
//     - With PULSE_TRAIN_PHASE_EN, phase=4 -> first period is 2 low cycles, then a normal period.

Source files
------------

// File: rtl/pulse_train_generator.sv
// Multi-channel pulse train generator: per-channel period/duty counters, continuous or counted bursts.
// Optional build macro PULSE_TRAIN_PHASE_EN adds a per-channel start phase input.
module pulse_train_generator #(
  parameter int N        = 8,
  parameter int CHANNELS = 2,
  parameter int BURST_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [CHANNELS-1:0]         ch_ena,
  input  logic [CHANNELS*N-1:0]       ticks,
  input  logic [CHANNELS*N-1:0]       high_ticks,
  input  logic [CHANNELS-1:0]         mode,
  input  logic [CHANNELS*BURST_W-1:0] burst_len,
  input  logic [CHANNELS-1:0]         start,
`ifdef PULSE_TRAIN_PHASE_EN
  input  logic [CHANNELS*N-1:0]       phase,
`endif
  output logic [CHANNELS-1:0]         out,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         done
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t             state_r, state_s;
    logic [N-1:0]       count_r, count_s, count_inc_s, entry_count_s;
    logic [N-1:0]       ticks_l_r, ticks_l_s, high_l_r, high_l_s;
    logic [N-1:0]       ticks_in_s, high_in_s;
    logic [BURST_W-1:0] burst_l_r, burst_l_s, burst_in_s;
    logic [BURST_W-1:0] pcnt_r, pcnt_s, pcnt_inc_s;
    logic               mode_l_r, mode_l_s;
    logic               out_r, out_s, busy_r, busy_s, done_r, done_s;

    assign ticks_in_s  = ticks[g*N +: N];
    assign high_in_s   = high_ticks[g*N +: N];
    assign burst_in_s  = burst_len[g*BURST_W +: BURST_W];
    assign count_inc_s = count_r + N'(1);
    assign pcnt_inc_s  = pcnt_r + BURST_W'(1);

`ifdef PULSE_TRAIN_PHASE_EN
    logic [N-1:0] phase_in_s;
    assign phase_in_s    = phase[g*N +: N];
    assign entry_count_s = (phase_in_s < ticks_in_s) ? phase_in_s : '0;
`else
    assign entry_count_s = '0;
`endif

    // Next-state and next-output logic for one channel
    always_comb begin
      state_s   = state_r;
      count_s   = count_r;
      ticks_l_s = ticks_l_r;
      high_l_s  = high_l_r;
      burst_l_s = burst_l_r;
      mode_l_s  = mode_l_r;
      pcnt_s    = pcnt_r;
      out_s     = out_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      case (state_r)
        ST_IDLE: begin
          count_s = '0;
          pcnt_s  = '0;
          out_s   = 1'b0;
          busy_s  = 1'b0;
          if (ena && ch_ena[g] && (ticks_in_s != '0) && (!mode[g] || start[g])) begin
            if (mode[g] && (burst_in_s == '0)) begin
              done_s = 1'b1;
            end else begin
              state_s   = ST_RUN;
              ticks_l_s = ticks_in_s;
              high_l_s  = high_in_s;
              burst_l_s = burst_in_s;
              mode_l_s  = mode[g];
              count_s   = entry_count_s;
              out_s     = (entry_count_s < high_in_s);
              busy_s    = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!ch_ena[g]) begin
            state_s = ST_IDLE;
            count_s = '0;
            pcnt_s  = '0;
            out_s   = 1'b0;
            busy_s  = 1'b0;
          end else if (!ena) begin
            out_s = 1'b0;
          end else if (count_r == (ticks_l_r - N'(1))) begin
            // Period boundary: duty/period reload here; burst length stays as latched on entry
            count_s   = '0;
            ticks_l_s = ticks_in_s;
            high_l_s  = high_in_s;
            if (mode_l_r && (pcnt_inc_s == burst_l_r)) begin
              state_s = ST_IDLE;
              pcnt_s  = '0;
              out_s   = 1'b0;
              busy_s  = 1'b0;
              done_s  = 1'b1;
            end else if (ticks_in_s == '0) begin
              state_s = ST_IDLE;
              pcnt_s  = '0;
              out_s   = 1'b0;
              busy_s  = 1'b0;
            end else begin
              pcnt_s = mode_l_r ? pcnt_inc_s : pcnt_r;
              out_s  = (high_in_s != '0);
            end
          end else begin
            count_s = count_inc_s;
            out_s   = (count_inc_s < high_l_r);
          end
        end
        default: begin
          state_s = ST_IDLE;
          count_s = '0;
          pcnt_s  = '0;
          out_s   = 1'b0;
          busy_s  = 1'b0;
        end
      endcase
    end

    // Channel state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_r   <= ST_IDLE;
        count_r   <= '0;
        ticks_l_r <= '0;
        high_l_r  <= '0;
        burst_l_r <= '0;
        mode_l_r  <= 1'b0;
        pcnt_r    <= '0;
        out_r     <= 1'b0;
        busy_r    <= 1'b0;
        done_r    <= 1'b0;
      end else begin
        state_r   <= state_s;
        count_r   <= count_s;
        ticks_l_r <= ticks_l_s;
        high_l_r  <= high_l_s;
        burst_l_r <= burst_l_s;
        mode_l_r  <= mode_l_s;
        pcnt_r    <= pcnt_s;
        out_r     <= out_s;
        busy_r    <= busy_s;
        done_r    <= done_s;
      end
    end

    assign out[g]  = out_r;
    assign busy[g] = busy_r;
    assign done[g] = done_r;
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator (N=3, CHANNELS=2); channel 1 runs a free continuous train
// alongside the channel 0 scenarios.
module tb_pulse_train_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] ch_ena;
  logic [5:0] ticks;
  logic [5:0] high_ticks;
  logic [1:0] mode;
  logic [15:0] burst_len;
  logic [1:0] start;
`ifdef PULSE_TRAIN_PHASE_EN
  logic [5:0] phase;
`endif
  logic [1:0] out;
  logic [1:0] busy;
  logic [1:0] done;

  int vec_cnt = 0;
  int err_cnt = 0;
  int k1      = 4;
  bit ch1_on  = 1'b0;

  pulse_train_generator #(.N(3), .CHANNELS(2), .BURST_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .ch_ena     (ch_ena),
    .ticks      (ticks),
    .high_ticks (high_ticks),
    .mode       (mode),
    .burst_len  (burst_len),
    .start      (start),
`ifdef PULSE_TRAIN_PHASE_EN
    .phase      (phase),
`endif
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock edge, then check channel 0 outputs and the channel 1 free-running train
  task automatic tick(input string tag, input logic eo, input logic eb, input logic ed);
    @(posedge clk);
    if (ch1_on && ena) k1 = (k1 + 1) % 5;
    #1;
    chk({tag, ".out0"}, out[0], eo);
    chk({tag, ".busy0"}, busy[0], eb);
    chk({tag, ".done0"}, done[0], ed);
    if (ch1_on) chk({tag, ".out1"}, out[1], ena ? (k1 < 2) : 1'b0);
  endtask

  initial begin
    rst = 1'b0; ena = 1'b0; ch_ena = 2'b00; ticks = 6'd0; high_ticks = 6'd0;
    mode = 2'b00; burst_len = 16'd0; start = 2'b00;
`ifdef PULSE_TRAIN_PHASE_EN
    phase = 6'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out", out, 2'b00);
    chk("reset.busy", busy, 2'b00);
    chk("reset.done", done, 2'b00);

    // Continuous: ch0 6/3, ch1 5/2, 10 periods of ch0
    ticks[2:0] = 3'd6; high_ticks[2:0] = 3'd3;
    ticks[5:3] = 3'd5; high_ticks[5:3] = 3'd2;
    ch_ena = 2'b11; ena = 1'b1; rst = 1'b1; ch1_on = 1'b1;
    for (int k = 0; k < 60; k++) tick("cont", (k % 6) < 3, 1'b1, 1'b0);

    // Freeze at count 4
    for (int k = 0; k < 5; k++) tick("pre_freeze", (k % 6) < 3, 1'b1, 1'b0);
    ena = 1'b0;
    for (int k = 0; k < 5; k++) tick("frozen", 1'b0, 1'b1, 1'b0);
    ena = 1'b1;
    tick("resume5", 1'b0, 1'b1, 1'b0);
    tick("resume0", 1'b1, 1'b1, 1'b0);
    tick("resume1", 1'b1, 1'b1, 1'b0);
    tick("resume2", 1'b1, 1'b1, 1'b0);

    // Period change at count 2: finishes 6-tick period, then 4-tick periods
    ticks[2:0] = 3'd4;
    tick("chg3", 1'b0, 1'b1, 1'b0);
    tick("chg4", 1'b0, 1'b1, 1'b0);
    tick("chg5", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) tick("per4", (k % 4) < 3, 1'b1, 1'b0);

    // Duty corners and zero period
    ch_ena[0] = 1'b0;
    tick("chdis", 1'b0, 1'b0, 1'b0);
    ticks[2:0] = 3'd6; high_ticks[2:0] = 3'd0; ch_ena[0] = 1'b1;
    for (int k = 0; k < 12; k++) tick("high0", 1'b0, 1'b1, 1'b0);
    ch_ena[0] = 1'b0;
    tick("chdis2", 1'b0, 1'b0, 1'b0);
    high_ticks[2:0] = 3'd7; ch_ena[0] = 1'b1;
    for (int k = 0; k < 12; k++) tick("high7", 1'b1, 1'b1, 1'b0);
    ch_ena[0] = 1'b0;
    tick("chdis3", 1'b0, 1'b0, 1'b0);
    ticks[2:0] = 3'd0; high_ticks[2:0] = 3'd3; ch_ena[0] = 1'b1;
    for (int k = 0; k < 4; k++) tick("ticks0", 1'b0, 1'b0, 1'b0);

    ch_ena = 2'b00; ch1_on = 1'b0;
    tick("ch1off", 1'b0, 1'b0, 1'b0);
    chk("ch1off.busy1", busy[1], 1'b0);
    chk("ch1off.out1", out[1], 1'b0);

    // Burst of 3 with retrigger attempts mid-burst and on the done edge
    ticks[2:0] = 3'd6; mode[0] = 1'b1; burst_len[7:0] = 8'd3; ch_ena[0] = 1'b1;
    tick("nostart", 1'b0, 1'b0, 1'b0);
    tick("nostart", 1'b0, 1'b0, 1'b0);
    start[0] = 1'b1;
    tick("b_entry", 1'b1, 1'b1, 1'b0);
    start[0] = 1'b0;
    for (int e = 1; e < 18; e++) begin
      start[0] = (e == 8);
      tick("burst", (e % 6) < 3, 1'b1, 1'b0);
    end
    start[0] = 1'b1;
    tick("b_done", 1'b0, 1'b0, 1'b1);
    start[0] = 1'b0;
    tick("b_after", 1'b0, 1'b0, 1'b0);
    tick("b_after2", 1'b0, 1'b0, 1'b0);

    // Re-arm, then reset mid-burst
    start[0] = 1'b1;
    tick("b2_entry", 1'b1, 1'b1, 1'b0);
    start[0] = 1'b0;
    for (int e = 1; e < 5; e++) tick("burst2", (e % 6) < 3, 1'b1, 1'b0);
    rst = 1'b0;
    tick("mid_rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int e = 0; e < 20; e++) tick("post_rst", 1'b0, 1'b0, 1'b0);

    // Zero-length burst: done next cycle, no run
    burst_len[7:0] = 8'd0; start[0] = 1'b1;
    tick("bl0_done", 1'b0, 1'b0, 1'b1);
    start[0] = 1'b0;
    tick("bl0_after", 1'b0, 1'b0, 1'b0);

`ifdef PULSE_TRAIN_PHASE_EN
    // Phase 4 on a 6/3 continuous train: two low cycles, then a normal period
    ch_ena[0] = 1'b0; mode[0] = 1'b0;
    tick("ph_dis", 1'b0, 1'b0, 1'b0);
    phase[2:0] = 3'd4; ch_ena[0] = 1'b1;
    tick("ph4_e", 1'b0, 1'b1, 1'b0);
    tick("ph4_5", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) tick("ph4_per", (k % 6) < 3, 1'b1, 1'b0);
    ch_ena[0] = 1'b0;
    tick("ph_dis2", 1'b0, 1'b0, 1'b0);
    phase[2:0] = 3'd7; ch_ena[0] = 1'b1;
    for (int k = 0; k < 6; k++) tick("ph7", (k % 6) < 3, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
